instr_fetch_mem: RTL

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 105 ++++++++++
 1 files changed

// File: rtl/instr_fetch_mem.sv
// Byte-wide program store feeding a LAT-stage (1 or 2) fetch pipeline; a response appears LAT cycles after acceptance.
// A stalled valid response freezes every stage and deasserts req_ready; the load port ignores stalls.
module instr_fetch_mem #(
    parameter int ADDR_W    = 9,
    parameter int LAT       = 1,
    parameter int ENDIAN    = 0,
    parameter int ALIGN_CHK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_instr,
    output logic              rsp_err,
    input  logic              rsp_stall
);
    localparam int DEPTH = 2**ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic              mis;
    logic              adv;
    logic              in_err;
    logic [31:0]       in_dat;
    logic              s0_vld, s0_err;
    logic [31:0]       s0_dat;

    // Memory has no reset so program contents survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (ld_en && !reset) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign a1 = req_addr + ADDR_W'(1);
    assign a2 = req_addr + ADDR_W'(2);
    assign a3 = req_addr + ADDR_W'(3);
    assign b0 = mem[req_addr];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];
    assign mis = (ALIGN_CHK != 0) && (req_addr[1:0] != 2'b00);

    assign adv       = !(rsp_valid && rsp_stall);
    assign req_ready = adv;

    // Bubbles and misaligned requests carry zero data, so invalid stages always read as zero.
    always_comb begin
        in_err = 1'b0;
        in_dat = '0;
        if (req_valid) begin
            if (mis) begin
                in_err = 1'b1;
            end else if (ENDIAN != 0) begin
                in_dat = {b3, b2, b1, b0};
            end else begin
                in_dat = {b0, b1, b2, b3};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_vld <= 1'b0;
            s0_err <= 1'b0;
            s0_dat <= '0;
        end else if (adv) begin
            s0_vld <= req_valid;
            s0_err <= in_err;
            s0_dat <= in_dat;
        end
    end

    if (LAT == 2) begin : g_lat2
        logic        s1_vld, s1_err;
        logic [31:0] s1_dat;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_vld <= 1'b0;
                s1_err <= 1'b0;
                s1_dat <= '0;
            end else if (adv) begin
                s1_vld <= s0_vld;
                s1_err <= s0_err;
                s1_dat <= s0_dat;
            end
        end

        assign rsp_valid = s1_vld;
        assign rsp_err   = s1_err;
        assign rsp_instr = s1_dat;
    end else begin : g_lat1
        assign rsp_valid = s0_vld;
        assign rsp_err   = s0_err;
        assign rsp_instr = s0_dat;
    end

endmodule
